// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts a word one bit per cycle toward MSB (s=1) or LSB (s=0)
// until the target bit is set. Optional `SEQ_NORM_ABORT_EN adds an abort input honoured in SHIFT.
module seq_normalizer #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2**N-1:0]  a,
  input  logic             s,
`ifdef SEQ_NORM_ABORT_EN
  input  logic             abort,
`endif
  output logic [2**N-1:0]  y,
  output logic [N-1:0]     amt,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_work;
  logic           r_dir;
  logic [N-1:0]   r_count;
  logic [W-1:0]   r_y;
  logic [N-1:0]   r_amt;
  logic           r_zero;
  logic           r_busy;
  logic           r_done;

  logic           w_hit;
  logic           w_allzero;
  logic           w_abort;
  logic [W-1:0]   w_next_work;

`ifdef SEQ_NORM_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Target bit depends on direction; an all-zero word can never hit and is caught separately.
  assign w_hit       = r_dir ? r_work[W-1] : r_work[0];
  assign w_allzero   = (r_work == '0);
  assign w_next_work = r_dir ? {r_work[W-2:0], 1'b0} : {1'b0, r_work[W-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_y     <= '0;
      r_amt   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work  <= a;
            r_dir   <= s;
            r_count <= '0;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_allzero) begin
            r_y     <= '0;
            r_amt   <= '0;
            r_zero  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_hit) begin
            r_y     <= r_work;
            r_amt   <= r_count;
            r_zero  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // A nonzero word reaches its target within W-1 shifts, so count cannot wrap.
            r_work  <= w_next_work;
            r_count <= r_count + N'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = r_y;
  assign amt  = r_amt;
  assign zero = r_zero;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_seq_normalizer.sv
// Randomized scoreboard bench for seq_normalizer (N=3): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_normalizer;

  localparam int N = 3;
  localparam int W = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  a;
  logic          s;
  logic [W-1:0]  y;
  logic [N-1:0]  amt;
  logic          zero;
  logic          busy;
  logic          done;
`ifdef SEQ_NORM_ABORT_EN
  logic          abort;
`endif

  seq_normalizer #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .s       (s),
`ifdef SEQ_NORM_ABORT_EN
    .abort   (abort),
`endif
    .y       (y),
    .amt     (amt),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [W-1:0] y;
    logic [N-1:0] amt;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   prev_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: normalization from the position of the highest/lowest set bit.
  function automatic exp_t model(input logic [W-1:0] av, input logic sv);
    exp_t e;
    int msb, lsb;
    msb = -1;
    lsb = -1;
    for (int i = 0; i < W; i++) if (av[i]) msb = i;
    for (int i = W - 1; i >= 0; i--) if (av[i]) lsb = i;
    e.cyc = 0;
    if (av == '0) begin
      e.y = '0; e.amt = '0; e.zero = 1'b1;
    end else if (sv) begin
      e.amt  = N'(W - 1 - msb);
      e.y    = av << (W - 1 - msb);
      e.zero = 1'b0;
    end else begin
      e.amt  = N'(lsb);
      e.y    = av >> lsb;
      e.zero = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (prev_done) chk("done_width", 32'd2, 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y", 32'(y), 32'(e.y));
          chk("amt", 32'(amt), 32'(e.amt));
          chk("zero", 32'(zero), 32'(e.zero));
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  task automatic run_op(input logic [W-1:0] av, input logic sv,
                        input bit poke_busy, input bit poke_done);
    exp_t e;
    bit got;
    @(negedge clk);
    start = 1'b1; a = av; s = sv;
    @(posedge clk);
    #1;
    start = 1'b0; a = W'($urandom); s = 1'($urandom);
    e = model(av, sv);
    // Done is visible in the cycle following edge (accept + 1 + amt).
    e.cyc = cyc + 1 + int'(e.amt);
    sb.push_back(e);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        start = 1'b0;
      end else begin
        chk("busy_during_op", 32'(busy), 32'd1);
        if (poke_busy && i == 1) begin
          start = 1'b1; a = W'($urandom); s = 1'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    if (poke_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("y_held", 32'(y), 32'(e.y));
    chk("amt_held", 32'(amt), 32'(e.amt));
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    a       = '0;
    s       = 1'b0;
`ifdef SEQ_NORM_ABORT_EN
    abort   = 1'b0;
`endif
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_amt", 32'(amt), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;

    run_op(8'b0001_0110, 1'b1, 0, 0);
    run_op(8'b0001_0110, 1'b0, 0, 0);
    run_op(8'h00, 1'b1, 0, 0);
    run_op(8'h00, 1'b0, 0, 0);
    run_op(8'h80, 1'b1, 0, 0);
    run_op(8'h01, 1'b1, 1, 0);
    run_op(8'h01, 1'b0, 0, 1);
    run_op(8'h80, 1'b0, 0, 0);

    // Reset two cycles into a long operation: no done, outputs cleared immediately.
    @(negedge clk);
    start = 1'b1; a = 8'h01; s = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_amt", 32'(amt), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    run_op(8'h40, 1'b1, 0, 0);

`ifdef SEQ_NORM_ABORT_EN
    run_op(8'b0001_0110, 1'b1, 0, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h01; s = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", 32'(y), 32'hB0);
    chk("abort_amt", 32'(amt), 32'd3);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
`endif

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] rv;
      rv = W'($urandom);
      if ($urandom_range(0, 7) == 0) rv = '0;
      run_op(rv, 1'($urandom), 0, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
